iobus_n_connect: RTL
====================

Name: iobus_n_connect

Overview:
Parametrised successor to the fixed six-slave I/O bus connector. It fans the PDP-6 I/O bus out from one master (the CPU/APR side) to NSLAVE peripherals and ORs their return lines back. It adds a per-slave enable mask, an optional registered return path, and a sticky contention detector. The contention detector flags read cycles where more than one slave drives read data. The block sits between the APR bus master and the peripheral instances in the top level.

Parameters:
NSLAVE, 8, number of slave ports (1..16)
READ_REG, 1, 1 = return path (pi_req, iob_read, dr_split, rdi_data) registered with 1-cycle latency; 0 = combinational
FWD_REG, 0, 1 = master-to-slave pulses and data registered with 1-cycle latency; 0 = combinational

Ports:
clk  in  1  bus clock
reset  in  1  asynchronous, active-low reset
slave_en  in  NSLAVE  per-slave enable; bit k gates slave k
m_iob_poweron, m_iob_reset, m_datao_clear, m_datao_set, m_cono_clear, m_cono_set, m_iob_fm_datai, m_iob_fm_status, m_rdi_pulse  in  1 each  master control pulses
m_ios  in  7  device select, bits [3:9]
m_iob_write  in  36  master write word, bits [0:35]
m_pi_req  out  7  OR of enabled slave PI requests, levels [1:7]
m_iob_read  out  36  m_iob_write OR enabled slave read words
m_dr_split, m_rdi_data  out  1 each  OR of enabled slaves
m_conflict  out  1  sticky: more than one slave drove read data in a datai/status cycle
m_conflict_mask  out  NSLAVE  responder set captured at the first conflict
s_iob_poweron, s_iob_reset, s_datao_clear, s_datao_set, s_cono_clear, s_cono_set, s_iob_fm_datai, s_iob_fm_status, s_rdi_pulse  out  NSLAVE each  bit k drives slave k
s_ios  out  NSLAVE*7  slave k occupies [k*7 +: 7]
s_iob_write  out  NSLAVE*36  slave k occupies [k*36 +: 36]; word bit 0 is the MSB of the slice
s_pi_req  in  NSLAVE*7  packed the same way as s_ios
s_iob_read  in  NSLAVE*36  packed the same way as s_iob_write
s_dr_split, s_rdi_data  in  NSLAVE each

Behaviour:
Reset (reset low, asynchronous):
- All registered outputs go to 0: m_*, s_* (when registered), m_conflict, m_conflict_mask.
- Registered outputs stay 0 until the first clk edge after reset is released.

Forward path:
- s_iob_poweron and s_iob_reset go to every slave regardless of slave_en.
- Other control pulses, ios and write data go to slave k only when slave_en[k]=1; disabled slaves see 0.
- FWD_REG=1 adds exactly one cycle to all forward signals, keeping them mutually aligned.

Return path:
- Only enabled slaves contribute. m_iob_read always includes m_iob_write.
- READ_REG=1: outputs reflect the inputs sampled at the previous clk edge.
- The slave_en sample point matches the data sample point, so changing the mask never produces a partial word.

Contention detector:
- It is always sequential, whatever READ_REG is set to.
- resp[k] = slave_en[k] AND (s_iob_read slice k is nonzero).
- In a cycle where the forward-aligned m_iob_fm_datai or m_iob_fm_status is high and popcount(resp) >= 2: set m_conflict and load m_conflict_mask = resp.
- Only the first conflict loads the mask. Later conflicts leave the mask unchanged while m_conflict=1.
- m_conflict and m_conflict_mask clear on a cycle where m_iob_reset=1. If a clear and a new conflict happen in the same cycle, the clear wins.
- A single responder, or zero responders, never sets m_conflict.

Boundary conditions:
- NSLAVE=1: the detector can never fire.
- slave_en all 0: m_iob_read = m_iob_write; m_pi_req = 0.
- Reset asserted mid-cycle: all state clears immediately; no pulse is emitted after reset is released.

Test Plan:
- Reset low, then release; all slaves drive 0 -> every output 0; m_conflict=0.
- slave_en=8'hFF; s3 pi_req=7'b0000100; s6 pi_req=7'b1000000 -> m_pi_req=7'b1000100, one cycle later with READ_REG=1 and combinationally with READ_REG=0.
- slave_en=8'hFB (slave 2 off); m_datao_set pulse -> s_datao_set=8'hFB; m_iob_reset pulse -> s_iob_reset=8'hFF.
- m_iob_fm_datai high; s1 read=36'o1, s5 read=36'o400000000000 -> m_iob_read=36'o400000000001; m_conflict=1; mask=8'h22; a later conflict on s0/s7 leaves mask=8'h22.
- Conflict set, then m_iob_reset pulse -> m_conflict=0, mask=0; then a single responder with datai -> m_conflict stays 0.
- FWD_REG=1: m_cono_set and m_iob_write=36'o777 applied together -> both appear on the enabled slaves exactly one cycle later, in the same cycle.

Source files
------------

// File: rtl/iobus_n_connect.sv
// PDP-6 I/O bus connector: fans one APR master out to NSLAVE peripherals,
// ORs their return lines back and flags multi-responder read cycles.
module iobus_n_connect #(
  parameter int unsigned NSLAVE   = 8,
  parameter bit          READ_REG = 1'b1,
  parameter bit          FWD_REG  = 1'b0,
  localparam int unsigned IOS_W   = 7,
  localparam int unsigned WORD_W  = 36,
  localparam int unsigned PI_W    = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NSLAVE-1:0]          slave_en,
  input  logic                       m_iob_poweron,
  input  logic                       m_iob_reset,
  input  logic                       m_datao_clear,
  input  logic                       m_datao_set,
  input  logic                       m_cono_clear,
  input  logic                       m_cono_set,
  input  logic                       m_iob_fm_datai,
  input  logic                       m_iob_fm_status,
  input  logic                       m_rdi_pulse,
  input  logic [IOS_W-1:0]           m_ios,
  input  logic [WORD_W-1:0]          m_iob_write,
  output logic [PI_W-1:0]            m_pi_req,
  output logic [WORD_W-1:0]          m_iob_read,
  output logic                       m_dr_split,
  output logic                       m_rdi_data,
  output logic                       m_conflict,
  output logic [NSLAVE-1:0]          m_conflict_mask,
  output logic [NSLAVE-1:0]          s_iob_poweron,
  output logic [NSLAVE-1:0]          s_iob_reset,
  output logic [NSLAVE-1:0]          s_datao_clear,
  output logic [NSLAVE-1:0]          s_datao_set,
  output logic [NSLAVE-1:0]          s_cono_clear,
  output logic [NSLAVE-1:0]          s_cono_set,
  output logic [NSLAVE-1:0]          s_iob_fm_datai,
  output logic [NSLAVE-1:0]          s_iob_fm_status,
  output logic [NSLAVE-1:0]          s_rdi_pulse,
  output logic [NSLAVE*IOS_W-1:0]    s_ios,
  output logic [NSLAVE*WORD_W-1:0]   s_iob_write,
  input  logic [NSLAVE*PI_W-1:0]     s_pi_req,
  input  logic [NSLAVE*WORD_W-1:0]   s_iob_read,
  input  logic [NSLAVE-1:0]          s_dr_split,
  input  logic [NSLAVE-1:0]          s_rdi_data
);

  localparam int unsigned FWD_W = 2 + 9*NSLAVE + NSLAVE*IOS_W + NSLAVE*WORD_W;
  localparam int unsigned RET_W = PI_W + WORD_W + 2;

  logic [NSLAVE*IOS_W-1:0]  w_ios;
  logic [NSLAVE*WORD_W-1:0] w_wr;
  logic [FWD_W-1:0]         w_fwd;
  logic [FWD_W-1:0]         w_fwd_q;
  logic                     w_fm_datai_a;
  logic                     w_fm_status_a;
  logic [PI_W-1:0]          w_pi;
  logic [WORD_W-1:0]        w_rd;
  logic                     w_drs;
  logic                     w_rdd;
  logic [NSLAVE-1:0]        w_resp;
  logic [RET_W-1:0]         w_ret;
  logic [RET_W-1:0]         w_ret_q;
  logic                     w_multi;
  logic                     r_conflict;
  logic [NSLAVE-1:0]        r_mask;

  // Per-slave gating of select code and write word
  always_comb begin
    w_ios = '0;
    w_wr  = '0;
    for (int k = 0; k < NSLAVE; k++) begin
      w_ios[k*IOS_W +: IOS_W]   = slave_en[k] ? m_ios : '0;
      w_wr[k*WORD_W +: WORD_W]  = slave_en[k] ? m_iob_write : '0;
    end
  end

  // Raw datai/status ride along so the detector sees them aligned with the slaves
  assign w_fwd = {m_iob_fm_datai, m_iob_fm_status,
                  {NSLAVE{m_iob_poweron}}, {NSLAVE{m_iob_reset}},
                  slave_en & {NSLAVE{m_datao_clear}},
                  slave_en & {NSLAVE{m_datao_set}},
                  slave_en & {NSLAVE{m_cono_clear}},
                  slave_en & {NSLAVE{m_cono_set}},
                  slave_en & {NSLAVE{m_iob_fm_datai}},
                  slave_en & {NSLAVE{m_iob_fm_status}},
                  slave_en & {NSLAVE{m_rdi_pulse}},
                  w_ios, w_wr};

  if (FWD_REG) begin : g_fwd_reg
    logic [FWD_W-1:0] r_fwd;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_fwd <= '0;
      else        r_fwd <= w_fwd;
    end
    assign w_fwd_q = r_fwd;
  end else begin : g_fwd_comb
    assign w_fwd_q = w_fwd;
  end

  assign {w_fm_datai_a, w_fm_status_a,
          s_iob_poweron, s_iob_reset, s_datao_clear, s_datao_set,
          s_cono_clear, s_cono_set, s_iob_fm_datai, s_iob_fm_status,
          s_rdi_pulse, s_ios, s_iob_write} = w_fwd_q;

  // Wired-OR of enabled slaves; the master's own write word is always on the bus
  always_comb begin
    w_pi   = '0;
    w_rd   = m_iob_write;
    w_drs  = 1'b0;
    w_rdd  = 1'b0;
    w_resp = '0;
    for (int k = 0; k < NSLAVE; k++) begin
      if (slave_en[k]) begin
        w_pi      = w_pi | s_pi_req[k*PI_W +: PI_W];
        w_rd      = w_rd | s_iob_read[k*WORD_W +: WORD_W];
        w_drs     = w_drs | s_dr_split[k];
        w_rdd     = w_rdd | s_rdi_data[k];
        w_resp[k] = |s_iob_read[k*WORD_W +: WORD_W];
      end
    end
  end

  assign w_ret = {w_pi, w_rd, w_drs, w_rdd};

  if (READ_REG) begin : g_ret_reg
    logic [RET_W-1:0] r_ret;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_ret <= '0;
      else        r_ret <= w_ret;
    end
    assign w_ret_q = r_ret;
  end else begin : g_ret_comb
    assign w_ret_q = w_ret;
  end

  assign {m_pi_req, m_iob_read, m_dr_split, m_rdi_data} = w_ret_q;

  // Two or more responders: clearing the lowest set bit leaves something behind
  assign w_multi = |(w_resp & (w_resp - NSLAVE'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_conflict <= 1'b0;
      r_mask     <= '0;
    end else if (m_iob_reset) begin
      r_conflict <= 1'b0;
      r_mask     <= '0;
    end else if ((w_fm_datai_a || w_fm_status_a) && w_multi) begin
      r_conflict <= 1'b1;
      if (!r_conflict) r_mask <= w_resp;
    end
  end

  assign m_conflict      = r_conflict;
  assign m_conflict_mask = r_mask;

endmodule
